proc_mcycle_ctrl: RTL and testbench
===================================

Name: proc_mcycle_ctrl

Overview:
Control unit for the multicycle TinyRV1 processor. It is the successor to the single-cycle control table. An FSM sequences fetch, decode, execute, memory and writeback over several cycles, using val/rdy handshakes to variable-latency instruction and data memories and an iterative multiplier. It generalises CSR I/O to p_num_io input and output channels. It traps on illegal instructions and illegal CSR numbers instead of emitting don't-cares.

Parameters:
- p_num_io, 3: number of CSR in/out channels, range 1..8. inK = CSR 0xFC2+K; outK = CSR 0x7C2+K.
- p_idx_w, $clog2(p_num_io) (min 1): width of the CSR channel index. Derived; not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c2d_pc_sel  out  2  0=pc+4, 1=jal/branch target, 2=jr target
- c2d_pc_en  out  1  PC register write enable
- c2d_ir_en  out  1  instruction register write enable
- c2d_imm_type  out  2  0=I, 1=S, 2=J, 3=B
- c2d_op2_sel  out  1  0=rf, 1=imm
- c2d_alu_func  out  1  0=add, 1=compare
- c2d_wb_sel  out  3  0=alu, 1=mul, 2=mem, 3=pc+4, 4=csr_in
- c2d_rf_wen  out  1  register file write enable
- c2d_csr_idx  out  p_idx_w  selected in/out channel
- c2d_out_en  out  p_num_io  one-hot outK write enable
- c2d_imemreq_val  out  1  instruction memory request valid
- d2c_imemreq_rdy  in  1  instruction memory request ready
- d2c_imemresp_val  in  1  instruction memory response valid
- c2d_dmemreq_val  out  1  data memory request valid
- c2d_dmemreq_type  out  1  0=read, 1=write
- d2c_dmemreq_rdy  in  1  data memory request ready
- d2c_dmemresp_val  in  1  data memory response valid
- c2d_mul_start  out  1  one-cycle multiplier start pulse
- d2c_mul_done  in  1  multiplier result valid
- d2c_inst  in  32  instruction register contents
- d2c_eq  in  1  rs1==rs2 from the datapath
- c2d_inst_done  out  1  one-cycle pulse when an instruction retires
- c2d_trap  out  1  sticky illegal-instruction or illegal-CSR flag

Behaviour:
- Outputs are Moore/Mealy from state plus decoded d2c_inst. Every enable, val, start and out_en is 0 unless stated below. Select fields are 0 when unused (no X).
- rst: state <= FETCH next edge. While rst=1 all outputs are 0, including c2d_trap. Reset mid-operation abandons the instruction; memories share rst.
- FETCH: imemreq_val=1. On imemreq_rdy go to IWAIT; otherwise hold with val stable.
- IWAIT: ir_en = imemresp_val. On resp_val go to DECODE.
- DECODE handling per instruction:
  - ADDI/ADD: wb=alu, rf_wen, pc_en (pc+4). Go to FETCH.
  - JAL: wb=pc+4, rf_wen, pc_sel=1, pc_en. Go to FETCH.
  - JR: pc_sel=2, pc_en. Go to FETCH.
  - BNE: op2=rf, alu=cmp, imm=B, pc_sel = d2c_eq ? 0 : 1, pc_en. Go to FETCH.
  - CSRR inK (K<p_num_io): wb=csr_in, csr_idx=K, rf_wen, pc_en. Go to FETCH.
  - CSRW outK: out_en[K]=1, csr_idx=K, pc_en. Go to FETCH.
  - CSR number outside the valid ranges: go to TRAP.
  - MUL: mul_start=1. Go to MULW.
  - LW/SW: go to MREQ.
  - Any other encoding: go to TRAP.
- MULW: on mul_done, wb=mul, rf_wen, pc_en. Go to FETCH.
- MREQ: dmemreq_val=1, type = SW. Imm is I for LW and S for SW; op2=imm, alu=add (held stable). On rdy go to MWAIT.
- MWAIT: on dmemresp_val, pc_en=1; for LW also wb=mem and rf_wen. Go to FETCH. SW also waits for its response (write ack) to keep ordering.
- TRAP: c2d_trap=1; no enables asserted; remain until rst.
- inst_done equals pc_en (exactly one pulse per retired instruction).
- Responses or mul_done arriving outside their wait state are ignored.
- Latency with zero-wait memory (rdy=1, resp the next cycle):
  - ALU/jump/CSR: 3 cycles.
  - LW/SW: 5 cycles.
  - MUL: 3 + multiplier latency.

Decomposition:
- Package proc_mcycle_pkg: state enum (FETCH, IWAIT, DECODE, MULW, MREQ, MWAIT, TRAP); pc_sel, imm_type, op2_sel, alu_func and wb_sel codes; CSR_IN_BASE=0xFC2 and CSR_OUT_BASE=0x7C2.
- Sub-module proc_mcycle_decode: combinational. Maps d2c_inst to instruction class, CSR index and CSR-legal flag. The FSM stays in proc_mcycle_ctrl.

Test Plan:
- ADDI x1,x0,5 with zero-wait memory: FETCH, IWAIT, DECODE. rf_wen=1, wb_sel=0, op2_sel=1 and inst_done pulse in cycle 3; next FETCH in cycle 4.
- imemreq_rdy low for 4 cycles, then resp delayed 3 cycles: imemreq_val held 5 cycles; ir_en asserted exactly once, in the resp cycle; no rf_wen or pc_en before DECODE.
- LW then SW, dmem rdy after 2 cycles, resp after 1:
  - LW: dmemreq_type=0; rf_wen with wb_sel=2 only in the resp cycle.
  - SW: dmemreq_type=1; rf_wen never asserted; pc_en on the ack.
- MUL with d2c_mul_done 8 cycles after start: mul_start is a single pulse; rf_wen with wb_sel=1 on the done cycle; total 11 cycles.
- BNE with d2c_eq=0, then 1: pc_sel 1, then 0; pc_en=1 both times.
- p_num_io=4:
  - CSRW 0x7C5: out_en=4'b1000, csr_idx=3.
  - CSRR 0xFC6 (K=4, out of range): TRAP, c2d_trap stays 1.
  - rst pulse then returns to FETCH with trap=0.

Source files
------------

// File: rtl/proc_mcycle_pkg.sv
// Shared encodings for the multicycle TinyRV1 control unit: FSM states,
// datapath select codes, instruction classes and CSR channel bases.
package proc_mcycle_pkg;

  typedef enum logic [2:0] {
    FETCH, IWAIT, DECODE, MULW, MREQ, MWAIT, TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_ADD, CLS_ADDI, CLS_MUL, CLS_LW, CLS_SW,
    CLS_JAL, CLS_JR, CLS_BNE, CLS_CSRR, CLS_CSRW
  } inst_cls_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JR    = 2'd2;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_J = 2'd2;
  localparam logic [1:0] IMM_B = 2'd3;

  localparam logic OP2_RF  = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_CMP = 1'b1;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MUL = 3'd1;
  localparam logic [2:0] WB_MEM = 3'd2;
  localparam logic [2:0] WB_PC4 = 3'd3;
  localparam logic [2:0] WB_CSR = 3'd4;

  localparam logic [11:0] CSR_IN_BASE  = 12'hFC2;
  localparam logic [11:0] CSR_OUT_BASE = 12'h7C2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/proc_mcycle_decode.sv
// Combinational TinyRV1 decode: instruction class, CSR channel index and
// whether the CSR number names an implemented channel. Zero latency.
module proc_mcycle_decode
  import proc_mcycle_pkg::*;
#(
  parameter  int p_num_io = 3,
  localparam int p_idx_w  = (p_num_io > 1) ? $clog2(p_num_io) : 1
) (
  input  logic [31:0]        inst,
  output inst_cls_t          cls,
  output logic [p_idx_w-1:0] csr_idx,
  output logic               csr_ok
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] csr;
  logic [11:0] in_off;
  logic [11:0] out_off;

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign funct7  = inst[31:25];
  assign csr     = inst[31:20];
  // Offsets wrap for numbers below the base, so one compare bounds both sides.
  assign in_off  = csr - CSR_IN_BASE;
  assign out_off = csr - CSR_OUT_BASE;

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'h00) cls = CLS_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'h01) cls = CLS_MUL;
      end
      OPC_OPIMM:  if (funct3 == 3'b000) cls = CLS_ADDI;
      OPC_LOAD:   if (funct3 == 3'b010) cls = CLS_LW;
      OPC_STORE:  if (funct3 == 3'b010) cls = CLS_SW;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   if (funct3 == 3'b000 && rd == 5'd0 && csr == 12'd0) cls = CLS_JR;
      OPC_BRANCH: if (funct3 == 3'b001) cls = CLS_BNE;
      OPC_SYSTEM: begin
        if (funct3 == 3'b010 && rs1 == 5'd0) cls = CLS_CSRR;
        else if (funct3 == 3'b001 && rd == 5'd0) cls = CLS_CSRW;
      end
      default: cls = CLS_ILL;
    endcase
  end

  always_comb begin
    csr_ok  = 1'b0;
    csr_idx = '0;
    if (cls == CLS_CSRR) begin
      csr_ok  = (in_off < 12'(p_num_io));
      csr_idx = p_idx_w'(in_off);
    end else if (cls == CLS_CSRW) begin
      csr_ok  = (out_off < 12'(p_num_io));
      csr_idx = p_idx_w'(out_off);
    end
  end

endmodule

// File: rtl/proc_mcycle_ctrl.sv
// Multicycle TinyRV1 control FSM: 3 cycles ALU/jump/CSR, 5 LW/SW, 3+N MUL with
// zero-wait memory; stalls in place on imem/dmem rdy/resp and mul_done.
module proc_mcycle_ctrl
  import proc_mcycle_pkg::*;
#(
  parameter  int p_num_io = 3,
  localparam int p_idx_w  = (p_num_io > 1) ? $clog2(p_num_io) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [1:0]          c2d_pc_sel,
  output logic                c2d_pc_en,
  output logic                c2d_ir_en,
  output logic [1:0]          c2d_imm_type,
  output logic                c2d_op2_sel,
  output logic                c2d_alu_func,
  output logic [2:0]          c2d_wb_sel,
  output logic                c2d_rf_wen,
  output logic [p_idx_w-1:0]  c2d_csr_idx,
  output logic [p_num_io-1:0] c2d_out_en,
  output logic                c2d_imemreq_val,
  input  logic                d2c_imemreq_rdy,
  input  logic                d2c_imemresp_val,
  output logic                c2d_dmemreq_val,
  output logic                c2d_dmemreq_type,
  input  logic                d2c_dmemreq_rdy,
  input  logic                d2c_dmemresp_val,
  output logic                c2d_mul_start,
  input  logic                d2c_mul_done,
  input  logic [31:0]         d2c_inst,
  input  logic                d2c_eq,
  output logic                c2d_inst_done,
  output logic                c2d_trap
);

  state_t             state;
  inst_cls_t          cls;
  logic [p_idx_w-1:0] dec_idx;
  logic               csr_ok;

  proc_mcycle_decode #(.p_num_io(p_num_io)) u_decode (
    .inst    (d2c_inst),
    .cls     (cls),
    .csr_idx (dec_idx),
    .csr_ok  (csr_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (d2c_imemreq_rdy)  state <= IWAIT;
        IWAIT:  if (d2c_imemresp_val) state <= DECODE;
        DECODE: begin
          case (cls)
            CLS_ADD, CLS_ADDI, CLS_JAL, CLS_JR, CLS_BNE: state <= FETCH;
            CLS_CSRR, CLS_CSRW: state <= csr_ok ? FETCH : TRAP;
            CLS_MUL:            state <= MULW;
            CLS_LW, CLS_SW:     state <= MREQ;
            default:            state <= TRAP;
          endcase
        end
        MULW:   if (d2c_mul_done)     state <= FETCH;
        MREQ:   if (d2c_dmemreq_rdy)  state <= MWAIT;
        MWAIT:  if (d2c_dmemresp_val) state <= FETCH;
        TRAP:   state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    c2d_pc_sel       = PC_PLUS4;
    c2d_pc_en        = 1'b0;
    c2d_ir_en        = 1'b0;
    c2d_imm_type     = IMM_I;
    c2d_op2_sel      = OP2_RF;
    c2d_alu_func     = ALU_ADD;
    c2d_wb_sel       = WB_ALU;
    c2d_rf_wen       = 1'b0;
    c2d_csr_idx      = '0;
    c2d_out_en       = '0;
    c2d_imemreq_val  = 1'b0;
    c2d_dmemreq_val  = 1'b0;
    c2d_dmemreq_type = 1'b0;
    c2d_mul_start    = 1'b0;
    c2d_trap         = 1'b0;
    // Reset forces every output low, the sticky trap flag included.
    if (!rst) begin
      case (state)
        FETCH: c2d_imemreq_val = 1'b1;
        IWAIT: c2d_ir_en = d2c_imemresp_val;
        DECODE: begin
          case (cls)
            CLS_ADDI: begin
              c2d_op2_sel = OP2_IMM;
              c2d_rf_wen  = 1'b1;
              c2d_pc_en   = 1'b1;
            end
            CLS_ADD: begin
              c2d_rf_wen = 1'b1;
              c2d_pc_en  = 1'b1;
            end
            CLS_JAL: begin
              c2d_imm_type = IMM_J;
              c2d_wb_sel   = WB_PC4;
              c2d_rf_wen   = 1'b1;
              c2d_pc_sel   = PC_BR;
              c2d_pc_en    = 1'b1;
            end
            CLS_JR: begin
              c2d_pc_sel = PC_JR;
              c2d_pc_en  = 1'b1;
            end
            CLS_BNE: begin
              c2d_alu_func = ALU_CMP;
              c2d_imm_type = IMM_B;
              c2d_pc_sel   = d2c_eq ? PC_PLUS4 : PC_BR;
              c2d_pc_en    = 1'b1;
            end
            CLS_CSRR: if (csr_ok) begin
              c2d_wb_sel  = WB_CSR;
              c2d_csr_idx = dec_idx;
              c2d_rf_wen  = 1'b1;
              c2d_pc_en   = 1'b1;
            end
            CLS_CSRW: if (csr_ok) begin
              c2d_out_en[dec_idx] = 1'b1;
              c2d_csr_idx         = dec_idx;
              c2d_pc_en           = 1'b1;
            end
            CLS_MUL: c2d_mul_start = 1'b1;
            default: ;
          endcase
        end
        MULW: if (d2c_mul_done) begin
          c2d_wb_sel = WB_MUL;
          c2d_rf_wen = 1'b1;
          c2d_pc_en  = 1'b1;
        end
        MREQ: begin
          c2d_dmemreq_val  = 1'b1;
          c2d_dmemreq_type = (cls == CLS_SW);
          c2d_imm_type     = (cls == CLS_SW) ? IMM_S : IMM_I;
          c2d_op2_sel      = OP2_IMM;
        end
        MWAIT: if (d2c_dmemresp_val) begin
          c2d_pc_en = 1'b1;
          if (cls == CLS_LW) begin
            c2d_wb_sel = WB_MEM;
            c2d_rf_wen = 1'b1;
          end
        end
        TRAP: c2d_trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign c2d_inst_done = c2d_pc_en;

endmodule

// File: tb/tb_proc_mcycle_ctrl.sv
// Directed bench for proc_mcycle_ctrl with four CSR channels; every cycle of
// each scenario is compared against a hand-written expected control word.
module tb_proc_mcycle_ctrl;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       ir_en;
    logic [1:0] imm_type;
    logic       op2_sel;
    logic       alu_func;
    logic [2:0] wb_sel;
    logic       rf_wen;
    logic [1:0] csr_idx;
    logic [3:0] out_en;
    logic       imemreq_val;
    logic       dmemreq_val;
    logic       dmemreq_type;
    logic       mul_start;
    logic       inst_done;
    logic       trap;
  } ctl_t;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD    = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_MUL    = 32'h0220_81B3; // mul  x3,x1,x2
  localparam logic [31:0] I_LW     = 32'h0000_A103; // lw   x2,0(x1)
  localparam logic [31:0] I_SW     = 32'h0020_A023; // sw   x2,0(x1)
  localparam logic [31:0] I_BNE    = 32'h0020_9463; // bne  x1,x2,8
  localparam logic [31:0] I_JAL    = 32'h0000_00EF; // jal  x1,0
  localparam logic [31:0] I_JR     = 32'h0000_8067; // jr   x1
  localparam logic [31:0] I_CSRW5  = 32'h7C50_9073; // csrw 0x7C5,x1
  localparam logic [31:0] I_CSRR3  = 32'hFC30_2173; // csrr x2,0xFC3
  localparam logic [31:0] I_CSRR6  = 32'hFC60_20F3; // csrr x1,0xFC6
  localparam logic [31:0] I_CSRW6  = 32'h7C60_9073; // csrw 0x7C6,x1
  localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;

  logic        clk, rst;
  logic [1:0]  c2d_pc_sel;
  logic        c2d_pc_en, c2d_ir_en;
  logic [1:0]  c2d_imm_type;
  logic        c2d_op2_sel, c2d_alu_func;
  logic [2:0]  c2d_wb_sel;
  logic        c2d_rf_wen;
  logic [1:0]  c2d_csr_idx;
  logic [3:0]  c2d_out_en;
  logic        c2d_imemreq_val, d2c_imemreq_rdy, d2c_imemresp_val;
  logic        c2d_dmemreq_val, c2d_dmemreq_type, d2c_dmemreq_rdy, d2c_dmemresp_val;
  logic        c2d_mul_start, d2c_mul_done;
  logic [31:0] d2c_inst;
  logic        d2c_eq, c2d_inst_done, c2d_trap;

  int n_cmp = 0;
  int n_bad = 0;

  proc_mcycle_ctrl #(.p_num_io(4)) dut (
    .clk(clk), .rst(rst),
    .c2d_pc_sel(c2d_pc_sel), .c2d_pc_en(c2d_pc_en), .c2d_ir_en(c2d_ir_en),
    .c2d_imm_type(c2d_imm_type), .c2d_op2_sel(c2d_op2_sel), .c2d_alu_func(c2d_alu_func),
    .c2d_wb_sel(c2d_wb_sel), .c2d_rf_wen(c2d_rf_wen), .c2d_csr_idx(c2d_csr_idx),
    .c2d_out_en(c2d_out_en), .c2d_imemreq_val(c2d_imemreq_val),
    .d2c_imemreq_rdy(d2c_imemreq_rdy), .d2c_imemresp_val(d2c_imemresp_val),
    .c2d_dmemreq_val(c2d_dmemreq_val), .c2d_dmemreq_type(c2d_dmemreq_type),
    .d2c_dmemreq_rdy(d2c_dmemreq_rdy), .d2c_dmemresp_val(d2c_dmemresp_val),
    .c2d_mul_start(c2d_mul_start), .d2c_mul_done(d2c_mul_done),
    .d2c_inst(d2c_inst), .d2c_eq(d2c_eq),
    .c2d_inst_done(c2d_inst_done), .c2d_trap(c2d_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ctl_t obs();
    ctl_t o;
    o.pc_sel       = c2d_pc_sel;
    o.pc_en        = c2d_pc_en;
    o.ir_en        = c2d_ir_en;
    o.imm_type     = c2d_imm_type;
    o.op2_sel      = c2d_op2_sel;
    o.alu_func     = c2d_alu_func;
    o.wb_sel       = c2d_wb_sel;
    o.rf_wen       = c2d_rf_wen;
    o.csr_idx      = c2d_csr_idx;
    o.out_en       = c2d_out_en;
    o.imemreq_val  = c2d_imemreq_val;
    o.dmemreq_val  = c2d_dmemreq_val;
    o.dmemreq_type = c2d_dmemreq_type;
    o.mul_start    = c2d_mul_start;
    o.inst_done    = c2d_inst_done;
    o.trap         = c2d_trap;
    return o;
  endfunction

  task automatic idle_inputs();
    d2c_imemreq_rdy  = 1'b0;
    d2c_imemresp_val = 1'b0;
    d2c_dmemreq_rdy  = 1'b0;
    d2c_dmemresp_val = 1'b0;
    d2c_mul_done     = 1'b0;
    d2c_eq           = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t e;
    for (int c = 1; c <= 2; c++) begin
      idle_inputs();
      d2c_inst = I_ADDI;
      e = '0;
      if (c == 1) begin
        rst = 1'b1;
        d2c_imemreq_rdy  = 1'b1;
        d2c_imemresp_val = 1'b1;
        d2c_mul_done     = 1'b1;
      end else begin
        rst = 1'b0;
        e.imemreq_val = 1'b1;
      end
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got %h expected %h", c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Zero-wait fetch, then one decode-cycle instruction, then the next FETCH.
  task automatic test_single(input string name, input logic [31:0] inst,
                             input logic eq, input ctl_t dec);
    ctl_t e;
    for (int c = 1; c <= 4; c++) begin
      idle_inputs();
      d2c_inst = inst;
      d2c_eq   = eq;
      e = '0;
      case (c)
        1: begin d2c_imemreq_rdy = 1'b1; e.imemreq_val = 1'b1; end
        2: begin d2c_imemresp_val = 1'b1; e.ir_en = 1'b1; end
        3: e = dec;
        default: e.imemreq_val = 1'b1;
      endcase
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imem_stall();
    ctl_t e;
    for (int c = 1; c <= 10; c++) begin
      idle_inputs();
      d2c_inst = I_ADD;
      e = '0;
      case (c)
        1, 2, 3, 4: e.imemreq_val = 1'b1;
        5: begin d2c_imemreq_rdy = 1'b1; e.imemreq_val = 1'b1; end
        6: begin d2c_dmemresp_val = 1'b1; d2c_mul_done = 1'b1; end
        7: ;
        8: begin d2c_imemresp_val = 1'b1; e.ir_en = 1'b1; end
        9: begin e.rf_wen = 1'b1; e.pc_en = 1'b1; e.inst_done = 1'b1; end
        default: e.imemreq_val = 1'b1;
      endcase
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL imem_stall cycle %0d: got %h expected %h", c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem(input string name, input logic [31:0] inst, input logic is_sw);
    ctl_t e;
    for (int c = 1; c <= 9; c++) begin
      idle_inputs();
      d2c_inst = inst;
      e = '0;
      case (c)
        1: begin d2c_imemreq_rdy = 1'b1; e.imemreq_val = 1'b1; end
        2: begin d2c_imemresp_val = 1'b1; e.ir_en = 1'b1; end
        3: ;
        4, 5, 6: begin
          d2c_dmemreq_rdy  = (c == 6);
          d2c_dmemresp_val = (c == 4);
          e.dmemreq_val  = 1'b1;
          e.dmemreq_type = is_sw;
          e.imm_type     = is_sw ? 2'd1 : 2'd0;
          e.op2_sel      = 1'b1;
        end
        7: ;
        8: begin
          d2c_dmemresp_val = 1'b1;
          e.pc_en = 1'b1;
          e.inst_done = 1'b1;
          if (!is_sw) begin e.wb_sel = 3'd2; e.rf_wen = 1'b1; end
        end
        default: e.imemreq_val = 1'b1;
      endcase
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    ctl_t e;
    for (int c = 1; c <= 12; c++) begin
      idle_inputs();
      d2c_inst = I_MUL;
      e = '0;
      case (c)
        1: begin d2c_imemreq_rdy = 1'b1; e.imemreq_val = 1'b1; end
        2: begin d2c_imemresp_val = 1'b1; e.ir_en = 1'b1; end
        3: e.mul_start = 1'b1;
        4, 6, 7, 8, 9, 10: ;
        5: d2c_dmemresp_val = 1'b1;
        11: begin
          d2c_mul_done = 1'b1;
          e.wb_sel = 3'd1; e.rf_wen = 1'b1; e.pc_en = 1'b1; e.inst_done = 1'b1;
        end
        default: e.imemreq_val = 1'b1;
      endcase
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL mul cycle %0d: got %h expected %h", c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap(input string name, input logic [31:0] inst);
    ctl_t e;
    for (int c = 1; c <= 8; c++) begin
      idle_inputs();
      d2c_inst = inst;
      rst = (c == 7);
      e = '0;
      case (c)
        1: begin d2c_imemreq_rdy = 1'b1; e.imemreq_val = 1'b1; end
        2: begin d2c_imemresp_val = 1'b1; e.ir_en = 1'b1; end
        3: ;
        4, 5, 6: begin
          d2c_imemreq_rdy  = 1'b1;
          d2c_imemresp_val = 1'b1;
          d2c_dmemreq_rdy  = 1'b1;
          d2c_dmemresp_val = 1'b1;
          d2c_mul_done     = 1'b1;
          e.trap = 1'b1;
        end
        7: ;
        default: e.imemreq_val = 1'b1;
      endcase
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ctl_t d;
    rst = 1'b1;
    d2c_inst = '0;
    idle_inputs();
    @(posedge clk); #1;

    test_reset();

    d = '0; d.op2_sel = 1'b1; d.rf_wen = 1'b1; d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("addi", I_ADDI, 1'b0, d);

    test_imem_stall();

    test_mem("lw", I_LW, 1'b0);
    test_mem("sw", I_SW, 1'b1);

    test_mul();

    d = '0; d.alu_func = 1'b1; d.imm_type = 2'd3; d.pc_sel = 2'd1;
    d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("bne_ne", I_BNE, 1'b0, d);
    d.pc_sel = 2'd0;
    test_single("bne_eq", I_BNE, 1'b1, d);

    d = '0; d.imm_type = 2'd2; d.wb_sel = 3'd3; d.rf_wen = 1'b1;
    d.pc_sel = 2'd1; d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("jal", I_JAL, 1'b0, d);

    d = '0; d.pc_sel = 2'd2; d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("jr", I_JR, 1'b0, d);

    d = '0; d.out_en = 4'b1000; d.csr_idx = 2'd3; d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("csrw_out3", I_CSRW5, 1'b0, d);

    d = '0; d.wb_sel = 3'd4; d.csr_idx = 2'd1; d.rf_wen = 1'b1;
    d.pc_en = 1'b1; d.inst_done = 1'b1;
    test_single("csrr_in1", I_CSRR3, 1'b0, d);

    test_trap("trap_csrr_in4", I_CSRR6);
    test_trap("trap_csrw_out4", I_CSRW6);
    test_trap("trap_illegal", I_BAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
